micro_sequencer: RTL and testbench
==================================

// Module: micro_sequencer
// PURPOSE
//  Microprogram sequencer for the ARM multicycle control unit; owns the control-state register.
//  Each cycle it selects the next state from one of: the instruction encoder's dispatch address,
//  state+1, the microstore's CR jump address, or a held state.
//  Selection uses ns_ctl from the microstore word of the current state, cond, and memory handshake moc.
//  A MOC watchdog aborts hung memory cycles; an instruction counter counts dispatches.
// PARAMETERS
//  AW           7    control-state address width
//  RESET_STATE  0    state loaded on reset; also target of increment wrap-around
//  FETCH_STATE  1    first fetch microstate; target for NOP dispatch, cond-fail and reserved ns_ctl
//  ABORT_STATE  126  state entered on MOC timeout
//  MOC_TIMEOUT  16   max cycles a WAIT_MOC state may wait for moc (>=1)
//  CNT_W        32   instr_count width
// PORTS
//  clk          in   1      system clock, rising edge
//  reset        in   1      asynchronous, active-high reset
//  stall        in   1      1 = freeze state, watchdog and counter this cycle
//  ns_ctl       in   3      next-state mode from microstore word of current state
//  cr_addr      in   AW     jump target from microstore word
//  enc_addr     in   AW     dispatch address from instruction encoder (0 = NOP/all-zero IR)
//  cond         in   1      ARM condition-code test result for current IR
//  moc          in   1      memory operation complete
//  state        out  AW     current control state (registered)
//  dispatch     out  1      registered pulse: previous cycle took a non-NOP ENCODE
//  mem_abort    out  1      registered pulse: previous cycle hit MOC timeout
//  instr_count  out  CNT_W  number of non-NOP dispatches since reset
// BEHAVIOUR
//  Reset (async, immediate): state=RESET_STATE, dispatch=0, mem_abort=0, instr_count=0, wdog=0.
//  Latency: next state is registered on the rising edge after ns_ctl/inputs are sampled (1 cycle).
//  stall=1: all registers hold; dispatch and mem_abort forced 0 next cycle; stall beats all ns_ctl.
//  ns_ctl decode (stall=0), inc = state+1 mod 2^AW; 127+1 wraps to RESET_STATE:
//   000 ENCODE : enc_addr!=0 -> enc_addr, dispatch=1, instr_count+1 (wraps mod 2^CNT_W);
//                enc_addr==0 -> FETCH_STATE, no dispatch, no count
//   001 INCR   : inc
//   010 JUMP   : cr_addr
//   011 CONDT  : cond ? cr_addr : FETCH_STATE   (ARM cond fail = instruction skipped)
//   100 WAITM  : moc ? inc : hold state; see watchdog
//   101 CONDF  : cond ? inc : cr_addr
//   110 HOLD   : hold state (halt/trap)
//   111 resvd  : FETCH_STATE
//  Watchdog (internal counter wdog, width clog2(MOC_TIMEOUT)+1):
//   - counts cycles in WAITM with moc=0; clears on moc=1 or any non-WAITM cycle
//   - when wdog==MOC_TIMEOUT-1 and moc=0: next state=ABORT_STATE, mem_abort=1, wdog cleared
//   - moc=1 on the timeout cycle wins: normal inc, no abort
//  Simultaneous: reset overrides all; stall overrides moc/timeout (wdog frozen, not cleared).
//  Reset mid-WAITM or mid-stall: state returns to RESET_STATE immediately, no pulse outputs.
//  Next-state logic is combinational from registered state + inputs; no combinational in->out paths.
// TESTING
//  1 reset asserted mid-run (async, between edges) -> state=0, instr_count=0, dispatch=0 immediately.
//  2 ns_ctl=000, enc_addr=7'd43 -> next state 43, dispatch=1 one cycle, instr_count 0->1;
//    enc_addr=0 -> state 1, dispatch=0, count unchanged.
//  3 ns_ctl=011, cond=0 -> state 1; cond=1, cr_addr=7'd20 -> state 20; ns_ctl=101, cond=1, state 20 -> 21.
//  4 WAITM at state 5, moc=0 for 3 cycles then 1 -> state 5 held 3 cycles, then 6; mem_abort stays 0.
//  5 WAITM, moc never asserted, MOC_TIMEOUT=16 -> after 16 cycles in state, state=126, mem_abort 1 cycle.
//  6 state=127, ns_ctl=001 -> state 0; stall=1 with ns_ctl=010 -> state, wdog, instr_count unchanged.

Source files
------------

// File: rtl/micro_sequencer.sv
// Microprogram sequencer for the multicycle ARM control unit: owns the control-state
// register, selects the next microstate, guards memory waits with a MOC watchdog.
module micro_sequencer #(
  parameter int AW          = 7,
  parameter int RESET_STATE = 0,
  parameter int FETCH_STATE = 1,
  parameter int ABORT_STATE = 126,
  parameter int MOC_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [2:0]       ns_ctl,
  input  logic [AW-1:0]    cr_addr,
  input  logic [AW-1:0]    enc_addr,
  input  logic             cond,
  input  logic             moc,
  output logic [AW-1:0]    state,
  output logic             dispatch,
  output logic             mem_abort,
  output logic [CNT_W-1:0] instr_count
);

  localparam int WW = $clog2(MOC_TIMEOUT) + 1;

  localparam logic [AW-1:0] RST_S   = AW'(RESET_STATE);
  localparam logic [AW-1:0] FETCH_S = AW'(FETCH_STATE);
  localparam logic [AW-1:0] ABORT_S = AW'(ABORT_STATE);
  localparam logic [AW-1:0] TOP_S   = {AW{1'b1}};
  localparam logic [WW-1:0] WD_LAST = WW'(MOC_TIMEOUT - 1);

  typedef enum logic [2:0] {
    NS_ENCODE = 3'b000,
    NS_INCR   = 3'b001,
    NS_JUMP   = 3'b010,
    NS_CONDT  = 3'b011,
    NS_WAITM  = 3'b100,
    NS_CONDF  = 3'b101,
    NS_HOLD   = 3'b110,
    NS_RESVD  = 3'b111
  } ns_mode_t;

  ns_mode_t         mode;
  logic [AW-1:0]    state_q, state_d, inc;
  logic [WW-1:0]    wdog_q, wdog_d;
  logic             dispatch_q, dispatch_d;
  logic             abort_q, abort_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign mode = ns_mode_t'(ns_ctl);

  // State register: every sequencer register resets together, asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RST_S;
      wdog_q     <= '0;
      dispatch_q <= 1'b0;
      abort_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      wdog_q     <= wdog_d;
      dispatch_q <= dispatch_d;
      abort_q    <= abort_d;
      count_q    <= count_d;
    end
  end

  // Next-state selection; a stall freezes state, watchdog and counter and drops pulses.
  always_comb begin
    inc        = (state_q == TOP_S) ? RST_S : state_q + AW'(1);
    state_d    = state_q;
    wdog_d     = '0;
    dispatch_d = 1'b0;
    abort_d    = 1'b0;
    count_d    = count_q;
    if (stall) begin
      wdog_d = wdog_q;
    end else begin
      unique case (mode)
        NS_ENCODE: begin
          if (enc_addr != '0) begin
            state_d    = enc_addr;
            dispatch_d = 1'b1;
            count_d    = count_q + CNT_W'(1);
          end else begin
            state_d = FETCH_S;
          end
        end
        NS_INCR:  state_d = inc;
        NS_JUMP:  state_d = cr_addr;
        NS_CONDT: state_d = cond ? cr_addr : FETCH_S;
        NS_WAITM: begin
          // moc on the final allowed cycle still completes normally.
          if (moc) begin
            state_d = inc;
          end else if (wdog_q == WD_LAST) begin
            state_d = ABORT_S;
            abort_d = 1'b1;
          end else begin
            wdog_d = wdog_q + WW'(1);
          end
        end
        NS_CONDF: state_d = cond ? inc : cr_addr;
        NS_HOLD:  state_d = state_q;
        NS_RESVD: state_d = FETCH_S;
        default:  state_d = FETCH_S;
      endcase
    end
  end

  // Outputs are taken straight from registers: no input-to-output paths.
  always_comb begin
    state       = state_q;
    dispatch    = dispatch_q;
    mem_abort   = abort_q;
    instr_count = count_q;
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: directed scenarios then randomized traffic, all outputs
// compared every cycle against a behavioural model of the sequencing rules.
module tb_micro_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [2:0]  ns_ctl;
  logic [6:0]  cr_addr;
  logic [6:0]  enc_addr;
  logic        cond;
  logic        moc;
  logic [6:0]  state;
  logic        dispatch;
  logic        mem_abort;
  logic [31:0] instr_count;

  int checks = 0;
  int failures = 0;

  // Reference model: plain integers describing the architectural meaning.
  int          m_state;
  int          m_waited;
  bit          m_disp;
  bit          m_abort;
  logic [31:0] m_count;
  logic [6:0]  exp_q[$];

  micro_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .ns_ctl(ns_ctl), .cr_addr(cr_addr),
    .enc_addr(enc_addr), .cond(cond), .moc(moc), .state(state), .dispatch(dispatch),
    .mem_abort(mem_abort), .instr_count(instr_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_state = 0; m_waited = 0; m_disp = 0; m_abort = 0; m_count = 0;
  endfunction

  function automatic void model_step();
    int nxt;
    int succ;
    succ = (m_state + 1) % 128;
    m_disp = 0;
    m_abort = 0;
    if (stall) return;
    nxt = m_state;
    if (ns_ctl != 3'd4) m_waited = 0;
    case (ns_ctl)
      3'd0: if (enc_addr != 0) begin nxt = enc_addr; m_disp = 1; m_count = m_count + 1; end
            else nxt = 1;
      3'd1: nxt = succ;
      3'd2: nxt = cr_addr;
      3'd3: nxt = cond ? int'(cr_addr) : 1;
      3'd4: begin
        if (moc) begin nxt = succ; m_waited = 0; end
        else if (m_waited + 1 >= 16) begin nxt = 126; m_abort = 1; m_waited = 0; end
        else m_waited = m_waited + 1;
      end
      3'd5: nxt = cond ? succ : int'(cr_addr);
      3'd6: nxt = m_state;
      default: nxt = 1;
    endcase
    m_state = nxt;
  endfunction

  // Driver: apply one cycle of inputs, clock it, compare all outputs.
  task automatic cycle(input logic [2:0] ns, input logic [6:0] cr, input logic [6:0] enc,
                       input logic c, input logic m, input logic st);
    logic [6:0] exp_s;
    ns_ctl = ns; cr_addr = cr; enc_addr = enc; cond = c; moc = m; stall = st;
    @(posedge clk);
    model_step();
    exp_q.push_back(7'(m_state));
    #1;
    exp_s = exp_q.pop_front();
    check_val("state", 32'(state), 32'(exp_s));
    check_val("dispatch", 32'(dispatch), 32'(m_disp));
    check_val("mem_abort", 32'(mem_abort), 32'(m_abort));
    check_val("instr_count", instr_count, m_count);
  endtask

  task automatic async_reset_pulse();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_val("rst_state", 32'(state), 32'd0);
    check_val("rst_count", instr_count, 32'd0);
    check_val("rst_dispatch", 32'(dispatch), 32'd0);
    check_val("rst_abort", 32'(mem_abort), 32'd0);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; ns_ctl = 3'd6; cr_addr = '0; enc_addr = '0; cond = 1'b0; moc = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    check_val("reset_state", 32'(state), 32'd0);
    check_val("reset_count", instr_count, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Dispatch, then NOP dispatch
    cycle(3'd0, 7'd0, 7'd43, 1'b0, 1'b0, 1'b0);
    check_val("dispatch_43", 32'(state), 32'd43);
    cycle(3'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    check_val("nop_fetch", 32'(state), 32'd1);
    // Conditional branches
    cycle(3'd3, 7'd20, 7'd0, 1'b0, 1'b0, 1'b0);
    cycle(3'd3, 7'd20, 7'd0, 1'b1, 1'b0, 1'b0);
    check_val("condt_taken", 32'(state), 32'd20);
    cycle(3'd5, 7'd9, 7'd0, 1'b1, 1'b0, 1'b0);
    check_val("condf_inc", 32'(state), 32'd21);
    cycle(3'd5, 7'd9, 7'd0, 1'b0, 1'b0, 1'b0);
    // Memory wait that completes
    cycle(3'd2, 7'd5, 7'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle(3'd4, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    cycle(3'd4, 7'd0, 7'd0, 1'b0, 1'b1, 1'b0);
    check_val("waitm_done", 32'(state), 32'd6);
    // Memory wait that times out
    cycle(3'd2, 7'd5, 7'd0, 1'b0, 1'b0, 1'b0);
    repeat (16) cycle(3'd4, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    check_val("timeout_state", 32'(state), 32'd126);
    check_val("timeout_pulse", 32'(mem_abort), 32'd1);
    cycle(3'd6, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    // moc arriving on the final allowed cycle wins
    cycle(3'd2, 7'd5, 7'd0, 1'b0, 1'b0, 1'b0);
    repeat (15) cycle(3'd4, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    cycle(3'd4, 7'd0, 7'd0, 1'b0, 1'b1, 1'b0);
    // Wrap-around and stall
    cycle(3'd2, 7'd127, 7'd0, 1'b0, 1'b0, 1'b0);
    cycle(3'd1, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    check_val("wrap", 32'(state), 32'd0);
    cycle(3'd0, 7'd0, 7'd33, 1'b0, 1'b0, 1'b0);
    cycle(3'd2, 7'd77, 7'd0, 1'b0, 1'b0, 1'b1);
    check_val("stall_hold", 32'(state), 32'd33);
    // Stall freezes the watchdog mid-wait
    cycle(3'd2, 7'd5, 7'd0, 1'b0, 1'b0, 1'b0);
    repeat (10) cycle(3'd4, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    repeat (4) cycle(3'd4, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1);
    repeat (6) cycle(3'd4, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    check_val("stall_wdog", 32'(mem_abort), 32'd1);
    // Reset in the middle of a wait
    cycle(3'd2, 7'd5, 7'd0, 1'b0, 1'b0, 1'b0);
    repeat (4) cycle(3'd4, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    async_reset_pulse();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] ns;
      ns = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) ns = 3'd4;
      cycle(ns, 7'($urandom_range(0, 127)),
            ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 299) == 0) async_reset_pulse();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
